// File: rtl/ysyx_22041461_trap_ctrl.sv
// ysyx_22041461_trap_ctrl: trap/return sequencer between execute and the
// machine-mode CSR file. Emits one CSR write per cycle (mepc, mcause,
// [mtval], mstatus), then a one-cycle PC redirect, holding flush throughout.
//
// Optional feature: define YSYX_22041461_TRAP_TVAL_EN to add an mtval write
// after mcause on the trap path (mret path unchanged).
//
// Handshake: a request transfers on a rising edge where req_valid & req_ready
// are both 1; req_ready is high only in IDLE, so upstream must hold the
// request (valid and payload) stable until it sees req_ready.
module ysyx_22041461_trap_ctrl #(
    parameter int XLEN   = 64,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_type,
    input  logic [XLEN-1:0]   req_pc,
    input  logic [XLEN-1:0]   req_tval,
    input  logic [XLEN-1:0]   csr_mtvec,
    input  logic [XLEN-1:0]   csr_mepc,
    input  logic [XLEN-1:0]   csr_mstatus,
    output logic              csr_we,
    output logic [CSR_AW-1:0] csr_waddr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              flush,
    output logic              busy,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_W_MEPC    = 3'd1,
        S_W_MCAUSE  = 3'd2,
        S_W_MTVAL   = 3'd3,
        S_W_MSTATUS = 3'd4,
        S_REDIRECT  = 3'd5
    } state_e;

    localparam logic [1:0] T_ECALL = 2'b00;
    localparam logic [1:0] T_MRET  = 2'b01;
    localparam logic [1:0] T_ILL   = 2'b10;
    localparam logic [1:0] T_EBRK  = 2'b11;

    localparam logic [CSR_AW-1:0] A_MSTATUS = CSR_AW'(12'h300);
    localparam logic [CSR_AW-1:0] A_MEPC    = CSR_AW'(12'h341);
    localparam logic [CSR_AW-1:0] A_MCAUSE  = CSR_AW'(12'h342);
    localparam logic [CSR_AW-1:0] A_MTVAL   = CSR_AW'(12'h343);

    state_e            state_q, state_d;
    logic [1:0]        type_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   tvec_q;
    logic [XLEN-1:0]   epc_q;
    logic [XLEN-1:0]   mstatus_q;
    logic              accept;
    logic [XLEN-1:0]   ms_trap;
    logic [XLEN-1:0]   ms_ret;
    logic [XLEN-1:0]   cause;

`ifdef YSYX_22041461_TRAP_TVAL_EN
    logic [XLEN-1:0]   tval_q;
    logic [XLEN-1:0]   mtval;
    logic              unused_bits;
    assign unused_bits = ^{csr_mtvec[1:0], csr_mepc[1:0]};
`else
    logic              unused_bits;
    assign unused_bits = ^{req_tval, csr_mtvec[1:0], csr_mepc[1:0]};
`endif

    assign accept = (state_q == S_IDLE) && req_valid;

    // State register and accept-time snapshot of request and CSR inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            type_q    <= 2'b00;
            pc_q      <= '0;
            tvec_q    <= '0;
            epc_q     <= '0;
            mstatus_q <= '0;
`ifdef YSYX_22041461_TRAP_TVAL_EN
            tval_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                type_q    <= req_type;
                pc_q      <= req_pc;
                tvec_q    <= {csr_mtvec[XLEN-1:2], 2'b00};
                epc_q     <= {csr_mepc[XLEN-1:2], 2'b00};
                mstatus_q <= csr_mstatus;
`ifdef YSYX_22041461_TRAP_TVAL_EN
                tval_q    <= req_tval;
`endif
            end
        end
    end

    // Write data derived from the snapshot: new mstatus images and cause code
    always_comb begin
        ms_trap         = mstatus_q;
        ms_trap[7]      = mstatus_q[3];
        ms_trap[3]      = 1'b0;
        ms_trap[12:11]  = 2'b11;
        ms_ret          = mstatus_q;
        ms_ret[3]       = mstatus_q[7];
        ms_ret[7]       = 1'b1;
        ms_ret[12:11]   = 2'b11;
        case (type_q)
            T_ILL:   cause = XLEN'(2);
            T_EBRK:  cause = XLEN'(3);
            default: cause = XLEN'(11);
        endcase
`ifdef YSYX_22041461_TRAP_TVAL_EN
        case (type_q)
            T_ILL:   mtval = tval_q;
            T_EBRK:  mtval = pc_q;
            default: mtval = '0;
        endcase
`endif
    end

    // Next-state logic and Moore outputs; idle values assigned first
    always_comb begin
        state_d        = state_q;
        req_ready      = 1'b0;
        csr_we         = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        flush          = 1'b1;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                flush     = 1'b0;
                if (req_valid) begin
                    state_d = (req_type == T_MRET) ? S_W_MSTATUS : S_W_MEPC;
                end
            end
            S_W_MEPC: begin
                csr_we    = 1'b1;
                csr_waddr = A_MEPC;
                csr_wdata = pc_q;
                state_d   = S_W_MCAUSE;
            end
            S_W_MCAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = A_MCAUSE;
                csr_wdata = cause;
`ifdef YSYX_22041461_TRAP_TVAL_EN
                state_d   = S_W_MTVAL;
`else
                state_d   = S_W_MSTATUS;
`endif
            end
`ifdef YSYX_22041461_TRAP_TVAL_EN
            S_W_MTVAL: begin
                csr_we    = 1'b1;
                csr_waddr = A_MTVAL;
                csr_wdata = mtval;
                state_d   = S_W_MSTATUS;
            end
`endif
            S_W_MSTATUS: begin
                csr_we    = 1'b1;
                csr_waddr = A_MSTATUS;
                csr_wdata = (type_q == T_MRET) ? ms_ret : ms_trap;
                state_d   = S_REDIRECT;
            end
            S_REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = (type_q == T_MRET) ? epc_q : tvec_q;
                state_d        = S_IDLE;
            end
            default: begin
                flush   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = flush;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ysyx_22041461_trap_ctrl.sv
// Self-checking bench for ysyx_22041461_trap_ctrl: randomized and directed
// requests, reference model producing expected CSR writes/redirects per cycle.
module tb_ysyx_22041461_trap_ctrl;

  localparam int W = 109;  // {cycle[31:0], is_redirect, addr[11:0], data[63:0]}
`ifdef YSYX_22041461_TRAP_TVAL_EN
  localparam int LEN_TRAP = 5;
`else
  localparam int LEN_TRAP = 4;
`endif
  localparam int LEN_MRET = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_valid = 1'b0;
  logic [1:0]  req_type = 2'b00;
  logic [63:0] req_pc = '0, req_tval = '0;
  logic [63:0] csr_mtvec = '0, csr_mepc = '0, csr_mstatus = '0;
  logic        req_ready, csr_we, redirect_valid, flush, busy;
  logic [11:0] csr_waddr;
  logic [63:0] csr_wdata, redirect_pc;
  logic [2:0]  dbg_state;

  ysyx_22041461_trap_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_pc(req_pc), .req_tval(req_tval),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .csr_mstatus(csr_mstatus),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .busy(busy), .dbg_state_o(dbg_state)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  bit busy_map[int];
  bit mon_en = 1'b0;
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ev(input int c, input bit k, input logic [11:0] a,
                                      input logic [63:0] d);
    return {32'(c), k, a, d};
  endfunction

  // reference model: expected event list and busy window for a request accepted in cycle t
  task automatic model_push(input int t, input logic [1:0] typ, input logic [63:0] pc,
                            input logic [63:0] tval, input logic [63:0] mtvec,
                            input logic [63:0] mepc, input logic [63:0] ms, output int len);
    logic [63:0] keep, ms_new, cause_v, tv;
    int off;
    keep = ms & ~64'h0000_0000_0000_1888;
    if (typ == 2'b01) begin
      ms_new = keep | (((ms >> 7) & 64'd1) << 3) | 64'h80 | 64'h1800;
      exp_q.push_back(ev(t + 1, 1'b0, 12'h300, ms_new));
      exp_q.push_back(ev(t + 2, 1'b1, 12'h000, mepc & ~64'd3));
      len = LEN_MRET;
    end else begin
      ms_new  = keep | (((ms >> 3) & 64'd1) << 7) | 64'h1800;
      cause_v = (typ == 2'b00) ? 64'd11 : (typ == 2'b10) ? 64'd2 : 64'd3;
      tv      = (typ == 2'b10) ? tval : (typ == 2'b11) ? pc : 64'd0;
      exp_q.push_back(ev(t + 1, 1'b0, 12'h341, pc));
      exp_q.push_back(ev(t + 2, 1'b0, 12'h342, cause_v));
      off = LEN_TRAP - 4;
      if (off == 1) exp_q.push_back(ev(t + 3, 1'b0, 12'h343, tv));
      exp_q.push_back(ev(t + 3 + off, 1'b0, 12'h300, ms_new));
      exp_q.push_back(ev(t + 4 + off, 1'b1, 12'h000, mtvec & ~64'd3));
      len = LEN_TRAP;
    end
    for (int k = t + 1; k <= t + len; k++) busy_map[k] = 1'b1;
  endtask

  // driver: present request (entered just after a rising edge), wait for acceptance
  task automatic issue(input logic [1:0] typ, input logic [63:0] pc, input logic [63:0] tval,
                       input logic [63:0] mtvec, input logic [63:0] mepc,
                       input logic [63:0] ms, output int t_acc);
    int len;
    bit ok;
    ok = 1'b0;
    t_acc = -1;
    req_type = typ; req_pc = pc; req_tval = tval;
    csr_mtvec = mtvec; csr_mepc = mepc; csr_mstatus = ms;
    req_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        t_acc = cyc;
        model_push(t_acc, typ, pc, tval, mtvec, mepc, ms, len);
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no req_ready expected acceptance at cycle %0d", cyc);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_type = 2'($urandom_range(0, 3));
    req_pc = {$urandom, $urandom}; req_tval = {$urandom, $urandom};
    csr_mtvec = {$urandom, $urandom}; csr_mepc = {$urandom, $urandom};
    csr_mstatus = {$urandom, $urandom};
  endtask

  // driver: synchronous reset for one edge, abandoning the rest of any sequence
  task automatic reset_now();
    int r;
    logic [W-1:0] kept[$];
    int drop[$];
    r = cyc;
    rst = 1'b1;
    foreach (exp_q[i]) if (int'(exp_q[i][108:77]) <= r) kept.push_back(exp_q[i]);
    exp_q = kept;
    foreach (busy_map[k]) if (k > r) drop.push_back(k);
    foreach (drop[i]) busy_map.delete(drop[i]);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // monitor: per-cycle handshake/flush checks, pop and compare each write/redirect
  always @(negedge clk) begin
    if (mon_en) begin
      logic [W-1:0] e, act;
      bit exp_b;
      exp_b = busy_map.exists(cyc);
      check("flush", 64'(flush), 64'(exp_b));
      check("busy", 64'(busy), 64'(exp_b));
      check("req_ready", 64'(req_ready), 64'(!exp_b));
      if (!csr_we) begin
        check("waddr_idle", 64'(csr_waddr), 64'd0);
        check("wdata_idle", csr_wdata, 64'd0);
      end
      while (exp_q.size() > 0 && int'(exp_q[0][108:77]) < cyc) begin
        e = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL missing_output: got nothing expected cyc=%0d redir=%0b addr=%h data=%h",
                 e[108:77], e[76], e[75:64], e[63:0]);
      end
      if (csr_we || redirect_valid) begin
        act = {32'(cyc), redirect_valid, csr_we ? csr_waddr : 12'h000,
               redirect_valid ? redirect_pc : csr_wdata};
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got redir=%0b addr=%h data=%h expected none at cycle %0d",
                   act[76], act[75:64], act[63:0], cyc);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (act !== e) begin
            errors++;
            $display("FAIL csr_event: got cyc=%0d redir=%0b addr=%h data=%h expected cyc=%0d redir=%0b addr=%h data=%h",
                     act[108:77], act[76], act[75:64], act[63:0],
                     e[108:77], e[76], e[75:64], e[63:0]);
          end
        end
      end
    end
  end

  initial begin
    int t1, t2;
    int g;
    logic [1:0] typ;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_csr_we", 64'(csr_we), 64'd0);
    check("rst_waddr", 64'(csr_waddr), 64'd0);
    check("rst_wdata", csr_wdata, 64'd0);
    check("rst_redirect_valid", 64'(redirect_valid), 64'd0);
    check("rst_redirect_pc", redirect_pc, 64'd0);
    check("rst_flush", 64'(flush), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // ecall
    issue(2'b00, 64'h8000_0100, 64'd0, 64'h8000_0401, 64'd0, 64'h8, t1);
    idle(6);
    // mret
    issue(2'b01, 64'h8000_0200, 64'd0, 64'h8000_0401, 64'h8000_0104, 64'h1880, t1);
    idle(4);
    // second request held while busy: accepted right after the redirect
    issue(2'b00, 64'h8000_0300, 64'd0, 64'h8000_0801, 64'd0, 64'h0, t1);
    issue(2'b11, 64'h8000_0400, 64'd0, 64'h8000_0C00, 64'd0, 64'h8, t2);
    check("b2b_accept_gap", 64'(t2 - t1), 64'(LEN_TRAP + 1));
    idle(7);
    // mret then immediate ecall
    issue(2'b01, 64'h0, 64'd0, 64'h0, 64'h8000_0106, 64'h80, t1);
    issue(2'b00, 64'h8000_0500, 64'd0, 64'h9000_0000, 64'd0, 64'h8, t2);
    check("mret_accept_gap", 64'(t2 - t1), 64'(LEN_MRET + 1));
    idle(7);
    // reset after the mepc write: mcause and redirect must never appear
    issue(2'b00, 64'h8000_0600, 64'd0, 64'h8000_0401, 64'd0, 64'h8, t1);
    reset_now();
    idle(6);
    // illegal instruction with a tval
    issue(2'b10, 64'h8000_0700, 64'h0000_0000_FFFF_FFFF, 64'h8000_0401, 64'd0, 64'h0, t1);
    idle(7);
    // ebreak with mtvec changing mid-sequence
    issue(2'b11, 64'h8000_0800, 64'd0, 64'h8000_0A01, 64'd0, 64'h8, t1);
    csr_mtvec = 64'h1000;
    idle(7);

    // randomized traffic with occasional mid-sequence reset
    repeat (60) begin
      typ = 2'($urandom_range(0, 3));
      issue(typ, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, {$urandom, $urandom}, t1);
      if ($urandom_range(0, 9) == 0) begin
        idle($urandom_range(0, 3));
        reset_now();
      end else begin
        g = $urandom_range(0, 3);
        idle(g);
      end
    end

    idle(10);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22041461_trap_ctrl.md
Name: ysyx_22041461_trap_ctrl

Overview:
- Multi-cycle trap/return sequencer between the execute stage and the machine-mode CSR file.
- Accepts ecall / ebreak / illegal-instruction / mret requests and drives one CSR write per cycle into the CSR file (mepc, mcause, mstatus).
- Finishes with a single-cycle PC redirect and holds a pipeline flush for the whole sequence.

Parameters:
- XLEN, 64, data/PC width.
- CSR_AW, 12, CSR address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  trap/return request from execute.
- req_ready  out  1  request accepted when valid & ready.
- req_type  in  2  00 ecall, 01 mret, 10 illegal, 11 ebreak.
- req_pc  in  XLEN  PC of the faulting/returning instruction.
- req_tval  in  XLEN  instruction bits; used only with the optional feature.
- csr_mtvec  in  XLEN  current mtvec from the CSR file.
- csr_mepc  in  XLEN  current mepc from the CSR file.
- csr_mstatus  in  XLEN  current mstatus from the CSR file.
- csr_we  out  1  CSR write strobe.
- csr_waddr  out  CSR_AW  CSR write address.
- csr_wdata  out  XLEN  CSR write data.
- redirect_valid  out  1  one-cycle PC redirect.
- redirect_pc  out  XLEN  redirect target.
- flush  out  1  kill younger instructions.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: rst=1 at a clk edge forces IDLE.
  - All outputs 0 except req_ready=1.
  - Internal latches cleared.
  - Reset in mid-sequence abandons remaining writes; no redirect is issued.
- req_ready=1 only in IDLE. Requests presented while busy are not accepted and must be held by the upstream stage.
- Accept cycle T (IDLE, req_valid=1) latches:
  - req_type, req_pc.
  - tvec_q = {csr_mtvec[63:2],2'b00} (direct mode only; mode bits ignored).
  - epc_q = {csr_mepc[63:2],2'b00}.
  - mstatus_q = csr_mstatus.
- Trap path (ecall/illegal/ebreak): IDLE -> W_MEPC -> W_MCAUSE -> W_MSTATUS -> REDIRECT -> IDLE.
  - W_MEPC (T+1): waddr 0x341, wdata req_pc.
  - W_MCAUSE (T+2): waddr 0x342, wdata 11 for ecall, 2 for illegal, 3 for ebreak.
  - W_MSTATUS (T+3): waddr 0x300, wdata = mstatus_q with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11.
  - REDIRECT (T+4): redirect_valid=1, redirect_pc=tvec_q.
- Return path (mret): IDLE -> W_MSTATUS -> REDIRECT -> IDLE.
  - W_MSTATUS (T+1): wdata = mstatus_q with MIE[3]=MPIE[7], MPIE[7]=1, MPP[12:11]=2'b11.
  - REDIRECT (T+2): redirect_pc=epc_q.
- csr_we=1 exactly in W_* states. csr_waddr/csr_wdata are 0 when csr_we=0.
- flush=1 from T+1 through REDIRECT inclusive. busy identical to flush.
- After REDIRECT: IDLE, req_ready=1 at T+5 (trap) / T+3 (mret). Back-to-back requests are accepted at that cycle.
- Values latched at accept are used throughout. CSR input changes during the sequence have no effect, including a csr_mtvec change mid-sequence.
- Other mstatus bits pass through unchanged.

Optional Feature:
- Macro YSYX_22041461_TRAP_TVAL_EN.
- Defined: the trap path inserts W_MTVAL after W_MCAUSE.
  - waddr 0x343.
  - wdata = req_tval latched at accept for illegal, req_pc for ebreak, 0 for ecall.
  - Trap latency +1: redirect at T+5, IDLE at T+6.
  - mret path unchanged.
- Undefined: no mtval write; req_tval unused; timings as in Behaviour.

Test Plan:
- ecall: req_pc=0x80000100, csr_mtvec=0x80000401, csr_mstatus=0x8 -> writes (0x341,0x80000100), (0x342,11), (0x300,0x1880) on T+1..T+3; redirect_pc=0x80000400 at T+4; flush T+1..T+4.
- mret: csr_mepc=0x80000104, csr_mstatus=0x1880 -> single write (0x300,0x1888) at T+1; redirect 0x80000104 at T+2; req_ready=1 at T+3.
- Busy rejection: second req_valid held from T+1 -> req_ready=0 until T+5; second request accepted at T+5, first sequence unaffected.
- Reset mid-sequence: rst=1 at T+2 of ecall -> next cycle IDLE, csr_we=0, no redirect_valid ever; mcause write not issued.
- Illegal with TVAL_EN: req_tval=0x00000000FFFFFFFF -> mcause=2, (0x343,0xFFFFFFFF) at T+3, mstatus at T+4, redirect at T+5. Without TVAL_EN: no 0x343 write, redirect at T+4.
- ebreak while csr_mtvec changes to 0x1000 at T+2 -> mcause=3, redirect_pc is the mtvec value sampled at T.
